// File: rtl/data_mem_responder.sv
// data_mem_responder: data-side memory responder for the MIPS32 MEM stage.
// Word-addressed RAM (combinational read, clocked write), a 16-byte MMIO
// window holding CYCLE / RD_CNT / WR_CNT / STATUS, and sticky error flags
// for misaligned, unmapped and read+write-together accesses.
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,           // word-index bits, at most 29
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000 // bits [3:0] ignored
) (
    input  logic        clk,
    input  logic        rst,            // synchronous, active-low
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    output logic [31:0] mem_result,
    output logic        mem_err
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    // Word offsets inside the MMIO window
    localparam logic [1:0] OFF_CYCLE  = 2'd0;
    localparam logic [1:0] OFF_RD_CNT = 2'd1;
    localparam logic [1:0] OFF_WR_CNT = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    logic [31:0]           ram_q [DEPTH];
    logic [31:0]           cycle_q,  cycle_d;
    logic [31:0]           rd_cnt_q, rd_cnt_d;
    logic [31:0]           wr_cnt_q, wr_cnt_d;
    logic [2:0]            status_q, status_d;   // {both_en, unmapped, misaligned}
    logic [2:0]            status_set, status_clr;
    logic                  mem_err_q;

    logic                  any_en;
    logic                  misaligned;
    logic                  ram_hit;
    logic                  mmio_hit;
    logic                  unmapped;
    logic                  ram_rd;
    logic                  ram_we;
    logic                  mmio_wr;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic [1:0]            mmio_off;

    // Address decode in priority order: misaligned, RAM, MMIO, unmapped.
    assign any_en     = mem_read_en | mem_write_en;
    assign misaligned = (mem_addr[1:0] != 2'b00);
    assign ram_hit    = !misaligned && (mem_addr[31:ADDR_WIDTH+2] == '0);
    assign mmio_hit   = !misaligned && !ram_hit && (mem_addr[31:4] == MMIO_BASE[31:4]);
    assign unmapped   = !misaligned && !ram_hit && !mmio_hit;
    assign ram_idx    = mem_addr[ADDR_WIDTH+1:2];
    assign mmio_off   = mem_addr[3:2];

    assign ram_rd  = mem_read_en  && ram_hit;
    assign ram_we  = rst && mem_write_en && ram_hit;   // no RAM write during reset
    assign mmio_wr = mem_write_en && mmio_hit;

    // Next-state for counters and STATUS; MMIO writes override the increment.
    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cycle_d    = cycle_q + 32'd1;
        rd_cnt_d   = rd_cnt_q + {31'd0, ram_rd};
        wr_cnt_d   = wr_cnt_q + {31'd0, ram_we};
        status_clr = 3'b000;
        if (mmio_wr) begin
            case (mmio_off)
                OFF_CYCLE:  cycle_d    = mem_write_data;
                OFF_RD_CNT: rd_cnt_d   = mem_write_data;
                OFF_WR_CNT: wr_cnt_d   = mem_write_data;
                OFF_STATUS: status_clr = mem_write_data[2:0];
                default:    status_clr = 3'b000;
            endcase
        end
        status_set = {mem_read_en & mem_write_en, any_en & unmapped, any_en & misaligned};
        // Applying the set after the clear makes a simultaneous set win.
        status_d   = (status_q & ~status_clr) | status_set;
    end

    // Control registers with synchronous active-low reset.
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_q   <= 32'd0;
            rd_cnt_q  <= 32'd0;
            wr_cnt_q  <= 32'd0;
            status_q  <= 3'b000;
            mem_err_q <= 1'b0;
        end else begin
            cycle_q   <= cycle_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            status_q  <= status_d;
            mem_err_q <= |status_d;
        end
    end

    // RAM write port; contents survive reset.
    // NOTE: the array has no reset branch, so it maps onto plain RAM and keeps data across reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= mem_write_data;
        end
    end

    // Combinational load data; zero in reset, with no read, or for error accesses.
    always_comb begin
        mem_result = 32'd0;
        if (rst && mem_read_en) begin
            if (ram_hit) begin
                mem_result = ram_q[ram_idx];
            end else if (mmio_hit) begin
                case (mmio_off)
                    OFF_CYCLE:  mem_result = cycle_q;
                    OFF_RD_CNT: mem_result = rd_cnt_q;
                    OFF_WR_CNT: mem_result = wr_cnt_q;
                    default:    mem_result = {29'd0, status_q};
                endcase
            end
        end
    end

    assign mem_err = mem_err_q;

endmodule
